// File: rtl/bidir_sw_pkg.sv
// Shared types for the bidirectional bus switch: per-channel state encoding
// and the command direction codes.
package bidir_sw_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_A2B  = 2'b01,
        ST_B2A  = 2'b10,
        ST_DEAD = 2'b11
    } state_t;

    localparam logic [1:0] DIR_OFF = 2'b00;
    localparam logic [1:0] DIR_A2B = 2'b01;
    localparam logic [1:0] DIR_B2A = 2'b10;
    localparam logic [1:0] DIR_BAD = 2'b11;

endpackage

// File: rtl/bidir_sw_chan.sv
// One switch channel: direction FSM, dead-time down-counter and the
// tri-state pass-through drivers between its A and B slices.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_OFF  | both slices released
//   ST_A2B  | B slice driven from A slice
//   ST_B2A  | A slice driven from B slice
//   ST_DEAD | reversal in progress, both released until counter expires
module bidir_sw_chan
    import bidir_sw_pkg::*;
#(
    parameter int W    = 8,
    parameter int DEAD = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_we_i,
    input  logic [1:0]   cmd_dir_i,
    inout  wire  [W-1:0] a_io,
    inout  wire  [W-1:0] b_io,
    output state_t       state_o
);

    localparam int CW = $clog2(DEAD + 1);

    state_t        state_q, state_d;
    state_t        tgt_q, tgt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          a_en, b_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            tgt_q   <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_OFF: begin
                if (cmd_we_i && cmd_dir_i == DIR_A2B) state_d = ST_A2B;
                if (cmd_we_i && cmd_dir_i == DIR_B2A) state_d = ST_B2A;
            end
            ST_A2B: begin
                if (cmd_we_i && cmd_dir_i == DIR_OFF) state_d = ST_OFF;
                if (cmd_we_i && cmd_dir_i == DIR_B2A) begin
                    state_d = ST_DEAD;
                    tgt_d   = ST_B2A;
                    cnt_d   = CW'(DEAD);
                end
            end
            ST_B2A: begin
                if (cmd_we_i && cmd_dir_i == DIR_OFF) state_d = ST_OFF;
                if (cmd_we_i && cmd_dir_i == DIR_A2B) begin
                    state_d = ST_DEAD;
                    tgt_d   = ST_A2B;
                    cnt_d   = CW'(DEAD);
                end
            end
            ST_DEAD: begin
                // The edge that takes the count from 1 to 0 is the exit edge.
                if (cnt_q <= CW'(1)) begin
                    state_d = tgt_q;
                    tgt_d   = ST_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    always_comb begin
        a_en    = (state_q == ST_B2A);
        b_en    = (state_q == ST_A2B);
        state_o = state_q;
    end

    assign b_io = b_en ? a_io : {W{1'bz}};
    assign a_io = a_en ? b_io : {W{1'bz}};

endmodule

// File: rtl/bidir_bus_switch.sv
// Multi-channel bidirectional bus switch: command decode, ready mux and
// reject pulse; each channel's FSM and drivers live in bidir_sw_chan.
module bidir_bus_switch
    import bidir_sw_pkg::*;
#(
    parameter  int CH   = 4,
    parameter  int W    = 8,
    parameter  int DEAD = 2,
    localparam int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [CHW-1:0]  cmd_ch,
    input  logic [1:0]      cmd_dir,
    inout  wire  [CH*W-1:0] a_io,
    inout  wire  [CH*W-1:0] b_io,
    output logic [2*CH-1:0] ch_state,
    output logic            err
);

    state_t          st [CH];
    logic   [CH-1:0] we;
    logic            ch_ok;
    logic            accept;
    logic            sel_dead;
    logic            err_q, err_d;

    // Out-of-range indices only exist when CH is not a power of two.
    if (CH == (1 << CHW)) begin : g_full
        assign ch_ok = 1'b1;
    end else begin : g_part
        assign ch_ok = (cmd_ch < CHW'(CH));
    end

    always_comb begin
        sel_dead = 1'b0;
        for (int k = 0; k < CH; k++) begin
            if (ch_ok && cmd_ch == CHW'(k) && st[k] == ST_DEAD) sel_dead = 1'b1;
        end
    end

    assign cmd_ready = ~sel_dead;
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        we = '0;
        for (int k = 0; k < CH; k++) begin
            we[k] = accept && ch_ok && (cmd_dir != DIR_BAD) && (cmd_ch == CHW'(k));
        end
    end

    assign err_d = accept && (!ch_ok || cmd_dir == DIR_BAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;

    for (genvar k = 0; k < CH; k++) begin : g_chan
        bidir_sw_chan #(
            .W    (W),
            .DEAD (DEAD)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .cmd_we_i  (we[k]),
            .cmd_dir_i (cmd_dir),
            .a_io      (a_io[k*W +: W]),
            .b_io      (b_io[k*W +: W]),
            .state_o   (st[k])
        );
        assign ch_state[2*k +: 2] = st[k];
    end

endmodule

// File: tb/tb_bidir_bus_switch.sv
// Randomized bench for bidir_bus_switch with a behavioural channel model,
// directed pinning checks, and a CH=3 instance for out-of-range indices.
module tb_bidir_bus_switch;

    localparam int CH   = 4;
    localparam int W    = 8;
    localparam int DEAD = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [1:0]      cmd_ch = '0;
    logic [1:0]      cmd_dir = '0;
    tri   [CH*W-1:0] a_io, b_io;
    logic [2*CH-1:0] ch_state;
    logic            err;

    logic [CH-1:0]   a_en = '1, b_en = '1;
    logic [CH*W-1:0] a_drv = '0, b_drv = '0;

    logic            cmd3_valid = 1'b0;
    logic            cmd3_ready;
    logic [1:0]      cmd3_ch = '0;
    logic [1:0]      cmd3_dir = '0;
    tri   [3*W-1:0]  a3_io, b3_io;
    logic [5:0]      ch_state3;
    logic            err3;

    int total = 0;
    int bad   = 0;

    // model: mode 0 OFF, 1 A2B, 2 B2A, 3 reversing
    int m_mode [CH];
    int m_left [CH];
    int m_pend [CH];
    bit m_err;

    always #5 clk = ~clk;

    for (genvar k = 0; k < CH; k++) begin : g_drv
        assign a_io[k*W +: W] = a_en[k] ? a_drv[k*W +: W] : {W{1'bz}};
        assign b_io[k*W +: W] = b_en[k] ? b_drv[k*W +: W] : {W{1'bz}};
    end

    bidir_bus_switch #(.CH(CH), .W(W), .DEAD(DEAD)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_dir(cmd_dir), .a_io(a_io), .b_io(b_io),
        .ch_state(ch_state), .err(err)
    );

    bidir_bus_switch #(.CH(3), .W(W), .DEAD(DEAD)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd3_valid), .cmd_ready(cmd3_ready),
        .cmd_ch(cmd3_ch), .cmd_dir(cmd3_dir), .a_io(a3_io), .b_io(b3_io),
        .ch_state(ch_state3), .err(err3)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        if (int'(cmd_ch) >= CH) return 1'b1;
        return m_mode[cmd_ch] != 3;
    endfunction

    function automatic logic [2*CH-1:0] exp_state();
        logic [2*CH-1:0] v;
        for (int k = 0; k < CH; k++) v[2*k +: 2] = 2'(m_mode[k]);
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            m_mode[k] = 0;
            m_left[k] = 0;
            m_pend[k] = 0;
        end
        m_err = 1'b0;
    endtask

    // The side the model says is passive gets driven by the bench.
    task automatic drive_bus();
        for (int k = 0; k < CH; k++) begin
            a_drv[k*W +: W] = W'($urandom);
            b_drv[k*W +: W] = W'($urandom);
            a_en[k] = (m_mode[k] != 2);
            b_en[k] = (m_mode[k] != 1);
        end
    endtask

    task automatic step();
        bit acc, rej;
        int k, d;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            acc = cmd_valid && exp_ready();
            rej = acc && (cmd_dir == 2'b11 || int'(cmd_ch) >= CH);
            for (int j = 0; j < CH; j++) begin
                if (m_mode[j] == 3) begin
                    m_left[j]--;
                    if (m_left[j] == 0) m_mode[j] = m_pend[j];
                end
            end
            if (acc && !rej) begin
                k = int'(cmd_ch);
                d = int'(cmd_dir);
                if (m_mode[k] == 0) m_mode[k] = d;
                else if (d == 0) m_mode[k] = 0;
                else if (d != m_mode[k]) begin
                    m_mode[k] = 3;
                    m_left[k] = DEAD;
                    m_pend[k] = d;
                end
            end
            m_err = rej;
        end
        #1;
        drive_bus();
    endtask

    always @(negedge clk) begin
        chk("ch_state", 64'(ch_state), 64'(exp_state()));
        chk("cmd_ready", 64'(cmd_ready), 64'(exp_ready()));
        chk("err", 64'(err), 64'(m_err));
        for (int k = 0; k < CH; k++) begin
            case (m_mode[k])
                1: begin
                    chk("b_from_a", 64'(b_io[k*W +: W]), 64'(a_drv[k*W +: W]));
                    chk("a_hold",   64'(a_io[k*W +: W]), 64'(a_drv[k*W +: W]));
                end
                2: begin
                    chk("a_from_b", 64'(a_io[k*W +: W]), 64'(b_drv[k*W +: W]));
                    chk("b_hold",   64'(b_io[k*W +: W]), 64'(b_drv[k*W +: W]));
                end
                default: begin
                    chk("a_idle", 64'(a_io[k*W +: W]), 64'(a_drv[k*W +: W]));
                    chk("b_idle", 64'(b_io[k*W +: W]), 64'(b_drv[k*W +: W]));
                end
            endcase
        end
    end

    task automatic cmd(input int ch, input int dir);
        cmd_valid = 1'b1;
        cmd_ch    = 2'(ch);
        cmd_dir   = 2'(dir);
    endtask

    initial begin
        int r;
        model_reset();
        drive_bus();
        repeat (3) step();
        rst_n = 1'b1;
        step();
        #2;
        chk("rst_state", 64'(ch_state), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_ready", 64'(cmd_ready), 64'h1);

        cmd(0, 1);
        step();
        cmd_valid = 1'b0;
        a_drv[7:0] = 8'hA5;
        #1;
        chk("a2b_state", 64'(ch_state[1:0]), 64'h1);
        chk("a2b_data", 64'(b_io[7:0]), 64'hA5);
        chk("a2b_a_undriven", 64'(a_io[7:0]), 64'hA5);

        cmd(0, 2);
        step();
        cmd_valid = 1'b0;
        #1;
        chk("rev_dead1", 64'(ch_state[1:0]), 64'h3);
        chk("rev_ready1", 64'(cmd_ready), 64'h0);
        step();
        #1;
        chk("rev_dead2", 64'(ch_state[1:0]), 64'h3);
        chk("rev_ready2", 64'(cmd_ready), 64'h0);
        step();
        b_drv[7:0] = 8'h3C;
        #1;
        chk("rev_b2a", 64'(ch_state[1:0]), 64'h2);
        chk("b2a_data", 64'(a_io[7:0]), 64'h3C);

        cmd(1, 1);
        step();
        cmd(1, 2);
        step();
        cmd(3, 1);
        step();
        cmd_valid = 1'b0;
        #1;
        chk("par_ch3", 64'(ch_state[7:6]), 64'h1);
        chk("par_ch1_dead", 64'(ch_state[3:2]), 64'h3);
        step();
        #1;
        chk("par_ch1_done", 64'(ch_state[3:2]), 64'h2);

        cmd(2, 3);
        step();
        cmd_valid = 1'b0;
        #1;
        chk("bad_dir_err", 64'(err), 64'h1);
        chk("bad_dir_state", 64'(ch_state), 64'h4A);
        step();
        #1;
        chk("bad_dir_err_clr", 64'(err), 64'h0);

        cmd3_valid = 1'b1;
        cmd3_ch    = 2'd3;
        cmd3_dir   = 2'd1;
        #1;
        chk("oor_ready", 64'(cmd3_ready), 64'h1);
        step();
        cmd3_valid = 1'b0;
        #1;
        chk("oor_err", 64'(err3), 64'h1);
        chk("oor_state", 64'(ch_state3), 64'h0);
        step();
        #1;
        chk("oor_err_clr", 64'(err3), 64'h0);

        cmd(0, 1);
        step();
        cmd_valid = 1'b0;
        #1;
        chk("rst_pre_dead", 64'(ch_state[1:0]), 64'h3);
        rst_n = 1'b0;
        model_reset();
        drive_bus();
        #1;
        chk("rst_abort_state", 64'(ch_state), 64'h0);
        chk("rst_abort_b", 64'(b_io), 64'(b_drv));
        step();
        rst_n = 1'b1;
        step();
        step();
        #1;
        chk("rst_stay_off", 64'(ch_state[1:0]), 64'h0);

        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_ch    = 2'($urandom_range(0, CH - 1));
            r         = $urandom_range(0, 7);
            cmd_dir   = (r == 7) ? 2'b11 : 2'(r % 3);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                model_reset();
                drive_bus();
            end
            step();
        end
        cmd_valid = 1'b0;
        step();
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
